sram_req_ctrl: RTL and testbench

//  Request/response front-end for the single-port SRAM model. Accepts read/write

---
 rtl/sram_req_ctrl.sv | 108 ++++++++++
 tb/tb_sram_req_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_ctrl.sv
// sram_req_ctrl: valid/ready request/response front-end for a single-port SRAM.
// Ports: req_* in, rsp_* out, sram_* pins, busy and completed-op counters.
module sram_req_ctrl #(
    parameter int WIDTH     = 32,
    parameter int DEPTH     = 8,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [DEPTH_LOG-1:0] req_addr,
    input  logic [WIDTH-1:0]     req_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [WIDTH-1:0]     rsp_rdata,
    output logic                 sram_cs,
    output logic                 sram_we,
    output logic [DEPTH_LOG-1:0] sram_addr,
    output logic [WIDTH-1:0]     sram_wdata,
    input  logic [WIDTH-1:0]     sram_rdata,
    output logic                 busy,
    output logic [CNT_W-1:0]     wr_count,
    output logic [CNT_W-1:0]     rd_count
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        READ,
        CAPTURE,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    state_t               state;
    logic [DEPTH_LOG-1:0] addr_q;
    logic [WIDTH-1:0]     wdata_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            wr_count  <= '0;
            rd_count  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        state   <= req_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    wr_count <= wr_count + CNT_ONE;
                    state    <= IDLE;
                end
                READ: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    // SRAM data_out is valid one cycle after the read strobe
                    rsp_rdata <= sram_rdata;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rd_count  <= rd_count + CNT_ONE;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // req_ready is gated by reset so nothing looks acceptable while held
    always_comb begin
        req_ready = 1'b0;
        sram_cs   = 1'b0;
        sram_we   = 1'b0;
        unique case (1'b1)
            (state == IDLE):  req_ready = reset;
            (state == WRITE): begin
                sram_cs = 1'b1;
                sram_we = 1'b1;
            end
            (state == READ):  sram_cs = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state != IDLE);
    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_sram_req_ctrl.sv
// tb_sram_req_ctrl: directed bench with a cycle-timeline model of the controller.
// Includes a behavioural SRAM (1-cycle registered read) as the downstream memory.
module tb_sram_req_ctrl;

    localparam int W   = 32;
    localparam int D   = 8;
    localparam int AW  = 3;
    localparam int CW  = 4;
    localparam int MOD = 1 << CW;
    localparam int BIG = 32'h7fff_ffff;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [AW-1:0] req_addr;
    logic [W-1:0]  req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [W-1:0]  rsp_rdata;
    logic          sram_cs;
    logic          sram_we;
    logic [AW-1:0] sram_addr;
    logic [W-1:0]  sram_wdata;
    logic [W-1:0]  sram_rdata;
    logic          busy;
    logic [CW-1:0] wr_count;
    logic [CW-1:0] rd_count;

    always #5 clk = ~clk;

    sram_req_ctrl #(
        .WIDTH(W),
        .DEPTH(D),
        .DEPTH_LOG(AW),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .sram_cs(sram_cs),
        .sram_we(sram_we),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .busy(busy),
        .wr_count(wr_count),
        .rd_count(rd_count)
    );

    logic [W-1:0] smem [D];

    always @(posedge clk) begin
        if (!reset) begin
            sram_rdata <= '0;
        end else if (sram_cs) begin
            if (sram_we) smem[sram_addr] <= sram_wdata;
            else         sram_rdata      <= smem[sram_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Timeline model: an accepted op at cycle t strobes at t+1; a write
    // frees the port at t+2; a read shows its data from t+3 until taken.
    int           mcyc      = 0;
    int           free_at   = BIG;
    int           strobe_at = -1;
    bit           strobe_wr = 1'b0;
    bit           pend      = 1'b0;
    int           rsp_at    = BIG;
    logic [W-1:0] pend_data = '0;
    logic [W-1:0] m_rdata   = '0;
    logic [AW-1:0] m_addr   = '0;
    logic [W-1:0] m_wdata   = '0;
    int           m_wr      = 0;
    int           m_rd      = 0;
    logic [W-1:0] mem_m [D];

    always @(negedge clk) begin
        bit e_ready;
        bit e_cs;
        bit e_we;
        bit e_rv;
        if (!reset) begin
            chk("m_rst_ready", 32'(req_ready), 0);
            chk("m_rst_cs", 32'(sram_cs), 0);
            chk("m_rst_we", 32'(sram_we), 0);
            chk("m_rst_rv", 32'(rsp_valid), 0);
            chk("m_rst_rdata", rsp_rdata, 0);
            chk("m_rst_addr", 32'(sram_addr), 0);
            chk("m_rst_wdata", sram_wdata, 0);
            chk("m_rst_busy", 32'(busy), 0);
            chk("m_rst_wr", 32'(wr_count), 0);
            chk("m_rst_rd", 32'(rd_count), 0);
            free_at   = mcyc + 1;
            strobe_at = -1;
            pend      = 1'b0;
            rsp_at    = BIG;
            m_rdata   = '0;
            m_addr    = '0;
            m_wdata   = '0;
            m_wr      = 0;
            m_rd      = 0;
        end else begin
            e_ready = (mcyc >= free_at);
            e_cs    = (mcyc == strobe_at);
            e_we    = e_cs && strobe_wr;
            e_rv    = pend && (mcyc >= rsp_at);
            chk("m_ready", 32'(req_ready), 32'(e_ready));
            chk("m_busy", 32'(busy), 32'(!e_ready));
            chk("m_cs", 32'(sram_cs), 32'(e_cs));
            chk("m_we", 32'(sram_we), 32'(e_we));
            chk("m_addr", 32'(sram_addr), 32'(m_addr));
            chk("m_wdata", sram_wdata, m_wdata);
            chk("m_rv", 32'(rsp_valid), 32'(e_rv));
            chk("m_rdata", rsp_rdata, m_rdata);
            chk("m_wr", 32'(wr_count), 32'(m_wr));
            chk("m_rd", 32'(rd_count), 32'(m_rd));
            if (e_we) m_wr = (m_wr + 1) % MOD;
            if (e_rv && rsp_ready) begin
                m_rd    = (m_rd + 1) % MOD;
                pend    = 1'b0;
                rsp_at  = BIG;
                free_at = mcyc + 1;
            end
            if (pend && (mcyc + 1 == rsp_at)) m_rdata = pend_data;
            if (e_ready && req_valid) begin
                m_addr    = req_addr;
                m_wdata   = req_wdata;
                strobe_at = mcyc + 1;
                strobe_wr = req_write;
                if (req_write) begin
                    mem_m[req_addr] = req_wdata;
                    free_at         = mcyc + 2;
                end else begin
                    pend      = 1'b1;
                    pend_data = mem_m[req_addr];
                    rsp_at    = mcyc + 3;
                    free_at   = BIG;
                end
            end
        end
        mcyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Returns 1 time unit after the accepting edge (cycle 1 of the op)
    task automatic issue(input logic w, input logic [AW-1:0] a,
                         input logic [W-1:0] d);
        bit ok = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = req_ready;
            step();
        end
        req_valid = 1'b0;
        chk("accept", 32'(ok), 1);
    endtask

    task automatic read_chk(input logic [AW-1:0] a, input logic [W-1:0] exp);
        issue(1'b0, a, '0);
        for (int i = 0; i < 10 && !rsp_valid; i++) step();
        chk("rsp_seen", 32'(rsp_valid), 1);
        chk("rsp_rdata", rsp_rdata, exp);
    endtask

    time t1;
    time t2;

    initial begin
        reset     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd3;
        req_wdata = 32'h1;
        rsp_ready = 1'b0;

        // reset hold with a pending request
        repeat (3) @(negedge clk);
        chk("t1_ready", 32'(req_ready), 0);
        chk("t1_cs", 32'(sram_cs), 0);
        chk("t1_rv", 32'(rsp_valid), 0);
        chk("t1_wr", 32'(wr_count), 0);
        chk("t1_rd", 32'(rd_count), 0);
        step();
        reset     = 1'b1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("t1_ready_rel", 32'(req_ready), 1);
        step();

        // single write
        issue(1'b1, 3'd3, 32'hDEAD_BEEF);
        chk("t2_cs", 32'(sram_cs), 1);
        chk("t2_we", 32'(sram_we), 1);
        chk("t2_addr", 32'(sram_addr), 3);
        chk("t2_wdata", sram_wdata, 32'hDEAD_BEEF);
        step();
        chk("t2_cs_off", 32'(sram_cs), 0);
        chk("t2_wr", 32'(wr_count), 1);
        chk("t2_ready", 32'(req_ready), 1);

        // read back, latency 3
        rsp_ready = 1'b1;
        issue(1'b0, 3'd3, '0);
        chk("t3_we", 32'(sram_we), 0);
        step();
        chk("t3_rv_c2", 32'(rsp_valid), 0);
        step();
        chk("t3_rv_c3", 32'(rsp_valid), 1);
        chk("t3_rdata", rsp_rdata, 32'hDEAD_BEEF);
        step();
        chk("t3_rd", 32'(rd_count), 1);
        chk("t3_ready", 32'(req_ready), 1);

        // backpressure with a competing request
        issue(1'b1, 3'd5, 32'h1234_5678);
        rsp_ready = 1'b0;
        issue(1'b0, 3'd5, '0);
        step();
        step();
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 3'd5;
        req_wdata = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk("t4_rv", 32'(rsp_valid), 1);
            chk("t4_rdata", rsp_rdata, 32'h1234_5678);
            chk("t4_ready", 32'(req_ready), 0);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("t4_rv_off", 32'(rsp_valid), 0);
        chk("t4_rd", 32'(rd_count), 2);
        chk("t4_wr", 32'(wr_count), 2);

        // back-to-back writes at the top and bottom address
        issue(1'b1, 3'd7, 32'hA5A5_A5A5);
        t1 = $time;
        issue(1'b1, 3'd0, 32'h5A5A_5A5A);
        t2 = $time;
        chk("t5_gap", 32'(t2 - t1), 20);
        read_chk(3'd7, 32'hA5A5_A5A5);
        read_chk(3'd0, 32'h5A5A_5A5A);
        step();

        // counter wrap: 4 writes so far plus 17 more
        for (int i = 0; i < 17; i++) issue(1'b1, 3'(i), 32'(i * 3 + 1));
        step();
        chk("wrap_wr", 32'(wr_count), 5);
        chk("wrap_rd", 32'(rd_count), 4);

        // reset while holding a response
        rsp_ready = 1'b0;
        issue(1'b0, 3'd7, '0);
        step();
        step();
        chk("t6_rv_pre", 32'(rsp_valid), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_rv_async", 32'(rsp_valid), 0);
        chk("t6_rd", 32'(rd_count), 0);
        chk("t6_busy", 32'(busy), 0);
        @(posedge clk);
        #1;
        reset     = 1'b1;
        rsp_ready = 1'b1;
        read_chk(3'd7, 32'd46);
        step();
        chk("t6_rd_after", 32'(rd_count), 1);
        chk("t6_ready", 32'(req_ready), 1);

        repeat (3) step();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
